// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg: shared FSM state type and constants for the byte pattern scanner
package seq_scan_pkg;
  localparam int BYTE_W = 8;
  localparam int PAT_W = 4;
  localparam logic [PAT_W-1:0] RST_PATTERN = 4'b1101;
  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;
endpackage

// File: rtl/seq_scan_ctrl_match.sv
// seq_match: serial 4-bit pattern matcher with per-byte history clear
//   clk, rst     clock, sync active-high reset
//   clr          clears history and fill count (start of a new byte)
//   bit_vld      bit_in is presented this cycle
//   pattern      4-bit pattern, oldest bit in [3]
//   hit          combinational, high when bit_in completes a match
module seq_match
  import seq_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             bit_vld,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);
  logic [PAT_W-2:0] r_hist;
  logic [2:0]       r_fill;
  // three earlier bits of this byte are needed before a window is complete
  assign hit = bit_vld && (r_fill >= 3'd3) && ({r_hist, bit_in} == pattern);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (bit_vld) begin
      r_hist <= {r_hist[PAT_W-3:0], bit_in};
      r_fill <= (r_fill == 3'd4) ? r_fill : r_fill + 3'd1;
    end
  end
endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: round-robin byte intake that counts serial 4-bit pattern hits per byte
//   req_valid/req_data0/req_data1  two requesters, byte taken when req_valid & req_ready
//   req_ready                      one-hot combinational accept, only in IDLE
//   cfg_we/cfg_pattern             pattern update, honoured only in IDLE
//   busy                           high outside IDLE
//   res_valid/res_id/res_cnt       one-cycle result pulse, id and hit count hold afterwards
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int DW = 8,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  input  logic [DW-1:0] req_data0,
  input  logic [DW-1:0] req_data1,
  output logic [1:0]    req_ready,
  input  logic          cfg_we,
  input  logic [PW-1:0] cfg_pattern,
  output logic          busy,
  output logic          res_valid,
  output logic          res_id,
  output logic [2:0]    res_cnt
);
  state_t        r_state;
  logic          r_last;
  logic          r_id;
  logic [DW-1:0] r_byte;
  logic [PW-1:0] r_pat;
  logic [PW-1:0] r_bpat;
  logic [2:0]    r_bitcnt;
  logic [2:0]    r_cnt;
  logic          r_res_valid;
  logic          r_res_id;
  logic [2:0]    r_res_cnt;
  logic [1:0]    w_gnt;
  logic          w_acc;
  logic          w_hit;
  logic          w_shift;
  logic [2:0]    w_cnt_nxt;
  // r_last holds the previous grant; with both valid, the other requester wins
  assign w_gnt[0]  = !rst && (r_state == IDLE) && req_valid[0] && (!req_valid[1] || r_last);
  assign w_gnt[1]  = !rst && (r_state == IDLE) && req_valid[1] && (!req_valid[0] || !r_last);
  assign w_acc     = |w_gnt;
  assign w_shift   = (r_state == SHIFT);
  assign w_cnt_nxt = r_cnt + {2'b00, w_hit};
  assign req_ready = w_gnt;
  assign busy      = (r_state != IDLE);
  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign res_cnt   = r_res_cnt;
  seq_match u_match (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_acc),
    .bit_vld(w_shift),
    .bit_in (r_byte[DW-1]),
    .pattern(r_bpat),
    .hit    (w_hit)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_id        <= 1'b0;
      r_byte      <= '0;
      r_pat       <= RST_PATTERN;
      r_bpat      <= RST_PATTERN;
      r_bitcnt    <= '0;
      r_cnt       <= '0;
      r_res_valid <= 1'b0;
      r_res_id    <= 1'b0;
      r_res_cnt   <= '0;
    end else begin
      r_res_valid <= 1'b0;
      if (r_state == IDLE) begin
        if (cfg_we) r_pat <= cfg_pattern;
        if (w_acc) begin
          r_state  <= SHIFT;
          r_last   <= w_gnt[1];
          r_id     <= w_gnt[1];
          r_byte   <= w_gnt[1] ? req_data1 : req_data0;
          // a same-cycle pattern write applies to the byte being accepted
          r_bpat   <= cfg_we ? cfg_pattern : r_pat;
          r_bitcnt <= '0;
          r_cnt    <= '0;
        end
      end else if (r_state == SHIFT) begin
        r_byte   <= {r_byte[DW-2:0], 1'b0};
        r_bitcnt <= r_bitcnt + 3'd1;
        r_cnt    <= w_cnt_nxt;
        if (r_bitcnt == 3'(DW - 1)) begin
          r_state     <= REPORT;
          r_res_valid <= 1'b1;
          r_res_id    <= r_id;
          r_res_cnt   <= w_cnt_nxt;
        end
      end else begin
        r_state <= IDLE;
      end
    end
  end
endmodule
